// File: rtl/paralelo_serial_scheduler.sv
// ============================================================================
//  Module   : paralelo_serial_scheduler
//  Function : Byte-rate controller in front of the 9-bit parallel-to-serial
//             converter. It sends the link start-up COM words, then
//             round-robin arbitrates NUM_REQ byte requesters onto paralelo.
//             When no requester has data, or the link is disabled, it
//             inserts idle words instead.
//  Options  : BURST_LOCK_EN - when defined, a requester keeps the grant for
//             up to MAX_BURST consecutive words while it stays valid.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module paralelo_serial_scheduler #(
  parameter int          NUM_REQ    = 2,
  parameter int          SYNC_COUNT = 4,
  parameter logic [7:0]  IDLE_CODE  = 8'hBC,
  parameter int          MAX_BURST  = 4
) (
  input  logic                   clk2f,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ*8-1:0]   data_in,
  input  logic [NUM_REQ-1:0]     valid_in,
  output logic [NUM_REQ-1:0]     ready_out,
  output logic [8:0]             paralelo,
  output logic [1:0]             grant_id,
  output logic [1:0]             estado,
  output logic                   sync_done
);

  localparam int CNT_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   sync_cnt;
  logic [1:0]         last;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [1:0]         gnt_idx;
  logic               found;
  logic               lock;
  logic [7:0]         sel_byte;

`ifdef BURST_LOCK_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  logic [BURST_W-1:0] burst;
  logic               last_valid;

  // Burst lock: keep the previous winner while it stays valid and has budget
  always_comb begin
    last_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == last) last_valid = valid_in[i];
    end
    lock = (burst != '0) && (burst < BURST_W'(MAX_BURST)) && last_valid;
  end
`else
  assign lock = 1'b0;
`endif

  // Grant selection: search starts just after the last winner, modulo NUM_REQ
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = last;
    found   = 1'b0;
    if (state == ST_ACTIVE && enable) begin
      if (lock) begin
        found = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (2'(i) == last) gnt_oh[i] = 1'b1;
        end
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid_in[i] && (((int'(last) + k) % NUM_REQ) == i)) begin
              found     = 1'b1;
              gnt_oh[i] = 1'b1;
              gnt_idx   = 2'(i);
            end
          end
        end
      end
    end
  end

  // One-hot byte mux driven by the grant vector
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) sel_byte = data_in[i*8 +: 8];
    end
  end

  assign ready_out = gnt_oh;
  assign estado    = state;
  assign sync_done = (state == ST_ACTIVE) || (state == ST_PAUSE);

  // Link state machine and registered serializer word
  always_ff @(posedge clk2f) begin
    if (reset) begin
      state    <= ST_RESET;
      paralelo <= {1'b0, IDLE_CODE};
      grant_id <= 2'd0;
      sync_cnt <= '0;
      last     <= 2'(NUM_REQ - 1);
    end else begin
      paralelo <= {1'b0, IDLE_CODE};
      case (state)
        ST_RESET: begin
          state    <= ST_SYNC;
          sync_cnt <= '0;
        end
        ST_SYNC: begin
          if (sync_cnt == CNT_W'(SYNC_COUNT - 1)) begin
            state    <= ST_ACTIVE;
            sync_cnt <= '0;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!enable) begin
            state <= ST_PAUSE;
          end else if (found) begin
            paralelo <= {1'b1, sel_byte};
            grant_id <= gnt_idx;
            last     <= gnt_idx;
          end
        end
        default: begin
          if (enable) state <= ST_ACTIVE;
        end
      endcase
    end
  end

`ifdef BURST_LOCK_EN
  // Burst length of the current grant holder; cleared on any break in the run
  always_ff @(posedge clk2f) begin
    if (reset) begin
      burst <= '0;
    end else if (state == ST_ACTIVE && enable && found) begin
      burst <= lock ? burst + 1'b1 : BURST_W'(1);
    end else begin
      burst <= '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_scheduler.sv
// ============================================================================
//  Module   : tb_paralelo_serial_scheduler
//  Function : Directed bench for paralelo_serial_scheduler (default build,
//             strict one-word round robin). Expected data words are queued
//             by the stimulus and checked by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_paralelo_serial_scheduler;

  logic        clk2f = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] data_in;
  logic [1:0]  valid_in;
  logic [1:0]  ready_out;
  logic [8:0]  paralelo;
  logic [1:0]  grant_id;
  logic [1:0]  estado;
  logic        sync_done;

  int total = 0;
  int bad   = 0;

  // Expected data words: {grant_id, paralelo}
  logic [10:0] exp_q[$];

  paralelo_serial_scheduler #(
    .NUM_REQ    (2),
    .SYNC_COUNT (4),
    .IDLE_CODE  (8'hBC),
    .MAX_BURST  (4)
  ) dut (
    .clk2f     (clk2f),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .paralelo  (paralelo),
    .grant_id  (grant_id),
    .estado    (estado),
    .sync_done (sync_done)
  );

  always #5 clk2f = ~clk2f;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and let registered outputs settle
  task automatic step();
    @(posedge clk2f);
    #1;
  endtask

  task automatic push(input logic [1:0] gid, input logic [8:0] word);
    exp_q.push_back({gid, word});
  endtask

  // Monitor: every flagged data word must match the head of the queue
  always @(negedge clk2f) begin
    if (paralelo[8] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {5'd0, grant_id, paralelo}, 16'h0000);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        chk("data_word", {5'd0, grant_id, paralelo}, {5'd0, e});
      end
    end
  end

  // Checks the four SYNC cycles followed by entry into ACTIVE
  task automatic check_sync(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_estado"}, {14'd0, estado}, 16'd1);
      chk({tag, "_word"}, {7'd0, paralelo}, 16'h00BC);
      chk({tag, "_ready"}, {14'd0, ready_out}, 16'd0);
      chk({tag, "_syncdone"}, {15'd0, sync_done}, 16'd0);
      step();
    end
    chk({tag, "_active"}, {14'd0, estado}, 16'd2);
    chk({tag, "_syncdone_hi"}, {15'd0, sync_done}, 16'd1);
    chk({tag, "_first_ready"}, {14'd0, ready_out}, 16'b01);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    valid_in = 2'b00;
    data_in  = 16'h0000;
    repeat (2) step();

    // Reset state
    chk("rst_estado", {14'd0, estado}, 16'd0);
    chk("rst_word", {7'd0, paralelo}, 16'h00BC);
    chk("rst_grant", {14'd0, grant_id}, 16'd0);
    chk("rst_syncdone", {15'd0, sync_done}, 16'd0);
    chk("rst_ready", {14'd0, ready_out}, 16'd0);

    // Start-up: four COM words with requesters already asking
    reset    = 1'b0;
    valid_in = 2'b11;
    data_in  = {8'h55, 8'hFF};
    step();
    check_sync("sync1");

    // Both valid: strict alternation starting at requester 0
    push(2'd0, 9'h1FF);
    push(2'd1, 9'h155);
    push(2'd0, 9'h1FF);
    push(2'd1, 9'h155);
    repeat (4) step();

    // Nobody valid: idle word, grant_id holds at 1
    valid_in = 2'b00;
    #1;
    chk("idle_ready", {14'd0, ready_out}, 16'd0);
    step();
    chk("idle_word", {7'd0, paralelo}, 16'h00BC);
    chk("idle_grant", {14'd0, grant_id}, 16'd1);

    // Only requester 1 valid; search wraps from 0 to 1
    valid_in = 2'b10;
    data_in  = {8'h30, 8'hFF};
    #1;
    chk("req1_ready", {14'd0, ready_out}, 16'b10);
    push(2'd1, 9'h130);
    step();

    // Link disable: grant withdrawn at once, PAUSE with idle words
    valid_in = 2'b11;
    data_in  = {8'h55, 8'hFF};
    enable   = 1'b0;
    #1;
    chk("dis_ready", {14'd0, ready_out}, 16'd0);
    step();
    chk("pause_estado", {14'd0, estado}, 16'd3);
    chk("pause_word", {7'd0, paralelo}, 16'h00BC);
    chk("pause_syncdone", {15'd0, sync_done}, 16'd1);
    step();
    chk("pause_ready", {14'd0, ready_out}, 16'd0);
    chk("pause_word2", {7'd0, paralelo}, 16'h00BC);

    // Re-enable: straight back to ACTIVE, next requester after 1 is 0
    enable = 1'b1;
    step();
    chk("resume_estado", {14'd0, estado}, 16'd2);
    chk("resume_ready", {14'd0, ready_out}, 16'b01);
    push(2'd0, 9'h1FF);
    step();
    push(2'd1, 9'h155);
    step();
    push(2'd0, 9'h1FF);
    step();
    chk("pre_reset_word", {7'd0, paralelo}, 16'h01FF);

    // Mid-stream reset: pending grant dropped, full resync follows
    reset = 1'b1;
    step();
    chk("mid_rst_word", {7'd0, paralelo}, 16'h00BC);
    chk("mid_rst_estado", {14'd0, estado}, 16'd0);
    chk("mid_rst_syncdone", {15'd0, sync_done}, 16'd0);
    reset = 1'b0;
    step();
    check_sync("sync2");
    push(2'd0, 9'h1FF);
    step();
    valid_in = 2'b00;
    repeat (3) step();

    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
